fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Sits on the other side of program_counter. It drives the counter's enable/load controls and reads instruction memory at the address the counter presents. Each fetched byte is latched into an instruction register and decoded. JMP and HLT are resolved locally; every other instruction is handed to the execute stage over a valid/ready handshake.

Parameters:
ADDR_WIDTH, 4, width of the PC value and memory address; matches program_counter width.
DATA_WIDTH, 8, instruction width; opcode = [DATA_WIDTH-1 -: 4], operand = [ADDR_WIDTH-1:0].
JMP_OPCODE, 4'h6, opcode that loads the PC with the operand.
HLT_OPCODE, 4'hF, opcode that stops fetching.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low (0 = reset); one clock, reset is asynchronous and active-low.
start  input  1  1-cycle pulse; begins fetching from IDLE or HALTED.
pc_value  input  ADDR_WIDTH  current program_counter counter_out.
pc_enable  output  1  increment strobe to program_counter.
pc_load  output  1  load strobe to program_counter.
pc_load_value  output  ADDR_WIDTH  load value to program_counter.
mem_req  output  1  read request, 1-cycle pulse.
mem_addr  output  ADDR_WIDTH  read address, valid when mem_req=1.
mem_rdata  input  DATA_WIDTH  read data.
mem_rvalid  input  1  mem_rdata valid this cycle; latency >=1 cycle after mem_req.
instr_out  output  DATA_WIDTH  current instruction register.
instr_valid  output  1  instr_out offered to execute stage.
instr_ready  input  1  execute stage accepts.
halted  output  1  high in HALTED state.

Behaviour:
- States: IDLE, FETCH, WAIT_MEM, DECODE, DISPATCH, HALTED.
- Reset (reset=0, asynchronous): state=IDLE. All outputs 0, including instr_out/IR, pc_load_value and mem_addr.
- IDLE/HALTED: all strobes 0. start=1 -> FETCH next edge; halted clears on the same edge. start in any other state is ignored.
- FETCH: mem_req=1 and mem_addr=pc_value for exactly one cycle -> WAIT_MEM.
- WAIT_MEM: wait for mem_rvalid=1. On that edge: IR<=mem_rdata, pc_enable=1 (combinational in that cycle, so the PC increments on the same edge), then go to DECODE. mem_rvalid outside WAIT_MEM is ignored.
- DECODE, one cycle, on the opcode of IR:
  - HLT_OPCODE: -> HALTED, halted=1 from the next cycle. The PC is already incremented past the HLT.
  - JMP_OPCODE: pc_load=1 and pc_load_value=operand for one cycle -> FETCH. The next fetch address is the operand.
  - Other opcodes: -> DISPATCH.
- DISPATCH: instr_valid=1 and instr_out stable until the cycle where instr_ready=1. That cycle is the transfer; go to FETCH next edge and drop instr_valid. instr_ready while instr_valid=0 is ignored.
- pc_enable and pc_load are never high in the same cycle; both are single-cycle pulses.
- Address wrap is the program_counter's job. 4'hF incremented to 4'h0 is fetched normally.
- Reset mid-operation (any state, including WAIT_MEM with a read outstanding or DISPATCH with instr_valid high): immediate return to IDLE. A late mem_rvalid after reset is ignored.
- Minimum throughput with 1-cycle memory and instr_ready held high: 4 cycles per dispatched instruction (FETCH, WAIT_MEM, DECODE, DISPATCH), 3 per JMP.

Test Plan:
- Reset/start: hold reset=0 -> all outputs 0 and state IDLE. Release, pulse start -> next cycle mem_req=1 with mem_addr=0.
- Straight-line: RAM[0..2]=8'h1A,8'h2B,8'hF0; bench PC model; 1-cycle RAM; instr_ready=1. Expect dispatch of 8'h1A then 8'h2B, then halted=1 with PC=3. Exactly two instr_valid transfers and three pc_enable pulses.
- Jump: RAM[0]=8'h6C, RAM[12]=8'hF0. Expect pc_enable at the fetch of address 0, pc_load=1 with pc_load_value=4'hC in DECODE, the next mem_addr=4'hC, then halted=1.
- Backpressure: RAM[0]=8'h35; hold instr_ready=0 for 5 cycles. Expect instr_valid=1 and instr_out=8'h35 stable throughout and no mem_req. Raise instr_ready -> one transfer, then mem_req with mem_addr=1.
- Wait states and wrap: RAM latency 3 cycles, PC preset to 4'hF. Expect IR unchanged until mem_rvalid and a single mem_req. After the increment, the next mem_addr=4'h0.
- Reset mid-op: assert reset during WAIT_MEM, then deliver mem_rvalid while in IDLE. Expect IR=0, instr_valid=0, no pc_enable, and state IDLE until the next start.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: program_counter control, instruction memory read and execute-stage handshake.
interface fetch_sequencer_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic start;
  logic [ADDR_WIDTH-1:0] pc_value;
  logic pc_enable;
  logic pc_load;
  logic [ADDR_WIDTH-1:0] pc_load_value;
  logic mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic mem_rvalid;
  logic [DATA_WIDTH-1:0] instr_out;
  logic instr_valid;
  logic instr_ready;
  logic halted;
  modport master (
    input  start, pc_value, mem_rdata, mem_rvalid, instr_ready,
    output pc_enable, pc_load, pc_load_value, mem_req, mem_addr, instr_out, instr_valid, halted
  );
  modport slave (
    output start, pc_value, mem_rdata, mem_rvalid, instr_ready,
    input  pc_enable, pc_load, pc_load_value, mem_req, mem_addr, instr_out, instr_valid, halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches, decodes and dispatches instructions; JMP and HLT are resolved locally.
module fetch_sequencer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter logic [3:0] JMP_OPCODE = 4'h6,
  parameter logic [3:0] HLT_OPCODE = 4'hF
) (
  input logic clk,
  input logic reset,
  fetch_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_MEM, DECODE, DISPATCH, HALTED} state_t;
  state_t state, state_nxt;
  logic [DATA_WIDTH-1:0] ir;
  logic [3:0] opcode;
  assign opcode = ir[DATA_WIDTH-1 -: 4];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ir <= '0;
    end else begin
      state <= state_nxt;
      if (bus.pc_enable) ir <= bus.mem_rdata;
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, HALTED: state_nxt = bus.start ? FETCH : state;
      FETCH:        state_nxt = WAIT_MEM;
      WAIT_MEM:     state_nxt = bus.mem_rvalid ? DECODE : WAIT_MEM;
      DECODE:       state_nxt = opcode == HLT_OPCODE ? HALTED : opcode == JMP_OPCODE ? FETCH : DISPATCH;
      DISPATCH:     state_nxt = bus.instr_ready ? FETCH : DISPATCH;
      default:      state_nxt = IDLE;
    endcase
  end
  // The PC increments on the same edge the read data lands in IR.
  assign bus.mem_req = state == FETCH;
  assign bus.mem_addr = bus.mem_req ? bus.pc_value : '0;
  assign bus.pc_enable = state == WAIT_MEM && bus.mem_rvalid;
  assign bus.pc_load = state == DECODE && opcode == JMP_OPCODE;
  assign bus.pc_load_value = bus.pc_load ? ir[ADDR_WIDTH-1:0] : '0;
  assign bus.instr_out = ir;
  assign bus.instr_valid = state == DISPATCH;
  assign bus.halted = state == HALTED;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector table, hand sequences and random programs checked
// against an instruction-level model of the fetch loop.
module tb_fetch_sequencer;
  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;
  fetch_sequencer_if bus();
  fetch_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0] ram [16];
  logic [3:0] pc = 4'h0;
  logic preset = 0;
  logic [3:0] preset_val = 4'h0;
  int mem_lat = 1;
  int cnt = 0;
  logic pend = 0;
  logic [3:0] paddr = 4'h0;

  // program_counter and variable-latency memory seen by the DUT
  assign bus.pc_value = pc;
  assign bus.mem_rvalid = pend && cnt == 1;
  assign bus.mem_rdata = bus.mem_rvalid ? ram[paddr] : 8'h00;
  always @(posedge clk) begin
    if (preset) pc <= preset_val;
    else if (bus.pc_load) pc <= bus.pc_load_value;
    else if (bus.pc_enable) pc <= pc + 4'd1;
    if (bus.mem_req) begin
      pend <= 1;
      cnt <= mem_lat;
      paddr <= bus.mem_addr;
    end else if (bus.mem_rvalid) pend <= 0;
    else if (pend) cnt <= cnt - 1;
  end

  int n_chk = 0, n_err = 0;
  int n_en, n_ld, n_req, n_both, n_stall_bad, cycles;
  bit stall_prev, saw_rvalid;
  logic [7:0] stall_ir, last_xfer;
  logic [7:0] xfer_q [$];
  logic [3:0] fetch_q [$];
  logic [7:0] mx_q [$];
  logic [3:0] mf_q [$];
  int m_en, m_ld;
  logic [3:0] m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    fetch_q.delete();
    xfer_q.delete();
    n_en = 0; n_ld = 0; n_req = 0; n_both = 0; n_stall_bad = 0; cycles = 0;
    stall_prev = 0; saw_rvalid = 0; last_xfer = 8'h00; stall_ir = 8'h00;
  endtask

  task automatic observe();
    if (bus.mem_req) begin
      n_req++;
      fetch_q.push_back(bus.mem_addr);
    end
    if (bus.mem_rvalid) saw_rvalid = 1;
    if (bus.pc_enable) n_en++;
    if (bus.pc_load) n_ld++;
    if (bus.pc_enable && bus.pc_load) n_both++;
    if (stall_prev && (!bus.instr_valid || bus.instr_out != stall_ir)) n_stall_bad++;
    stall_prev = bus.instr_valid && !bus.instr_ready;
    stall_ir = bus.instr_out;
    if (bus.instr_valid && bus.instr_ready) begin
      xfer_q.push_back(bus.instr_out);
      last_xfer = bus.instr_out;
    end
    cycles++;
  endtask

  // mode: 0 = ready low, 1 = ready high, 2 = random ready
  task automatic step(input int mode);
    bus.instr_ready = mode == 2 ? 1'($urandom_range(0, 1)) : mode == 1;
    observe();
    @(negedge clk);
  endtask

  task automatic launch(input logic [3:0] pc0);
    clear_stats();
    preset = 1;
    preset_val = pc0;
    bus.start = 1;
    @(negedge clk);
    preset = 0;
    bus.start = 0;
  endtask

  task automatic run_to_halt(input int mode, input int budget);
    while (!bus.halted && cycles < budget) step(mode);
    chk("halt_reached", 32'(bus.halted), 1);
  endtask

  // Instruction-level reference: what gets fetched, dispatched, and where the PC ends.
  function automatic bit model(input logic [3:0] pc0);
    logic [3:0] p;
    logic [7:0] ins;
    p = pc0;
    mx_q.delete();
    mf_q.delete();
    m_en = 0;
    m_ld = 0;
    m_pc = 4'h0;
    for (int i = 0; i < 40; i++) begin
      ins = ram[p];
      mf_q.push_back(p);
      p = p + 4'd1;
      m_en++;
      if (ins[7:4] == 4'hF) begin
        m_pc = p;
        return 1;
      end
      if (ins[7:4] == 4'h6) begin
        p = ins[3:0];
        m_ld++;
      end else mx_q.push_back(ins);
    end
    return 0;
  endfunction

  task automatic compare(input string tag);
    chk({tag, ".xfer_count"}, xfer_q.size(), mx_q.size());
    for (int i = 0; i < mx_q.size() && i < xfer_q.size(); i++) chk({tag, ".xfer"}, 32'(xfer_q[i]), 32'(mx_q[i]));
    chk({tag, ".fetch_count"}, fetch_q.size(), mf_q.size());
    for (int i = 0; i < mf_q.size() && i < fetch_q.size(); i++) chk({tag, ".fetch_addr"}, 32'(fetch_q[i]), 32'(mf_q[i]));
    chk({tag, ".pc_enables"}, n_en, m_en);
    chk({tag, ".pc_loads"}, n_ld, m_ld);
    chk({tag, ".pc_final"}, 32'(pc), 32'(m_pc));
    chk({tag, ".en_and_load"}, n_both, 0);
    chk({tag, ".stall_stable"}, n_stall_bad, 0);
  endtask

  task automatic fill_hlt();
    foreach (ram[i]) ram[i] = 8'hF0;
  endtask

  typedef struct {
    logic [3:0] a0, a1, a2;
    logic [7:0] d0, d1, d2;
    logic [3:0] pc0;
    int lat;
    int xfers;
    logic [7:0] last;
    logic [3:0] pc_end;
    int en, ld;
    logic [3:0] fetch1;
    int cyc;
  } vec_t;
  vec_t vecs [3];

  initial begin
    bus.start = 0;
    bus.instr_ready = 0;
    fill_hlt();
    vecs[0] = '{4'h0, 4'h1, 4'h2, 8'h1A, 8'h2B, 8'hF0, 4'h0, 1, 2, 8'h2B, 4'h3, 3, 0, 4'h1, 11};
    vecs[1] = '{4'h0, 4'hC, 4'hC, 8'h6C, 8'hF0, 8'hF0, 4'h0, 1, 0, 8'h00, 4'hD, 2, 1, 4'hC, 6};
    vecs[2] = '{4'hF, 4'h0, 4'h0, 8'h47, 8'hF0, 8'hF0, 4'hF, 3, 1, 8'h47, 4'h1, 2, 0, 4'h0, 11};

    repeat (3) @(negedge clk);
    chk("rst.mem_req", 32'(bus.mem_req), 0);
    chk("rst.mem_addr", 32'(bus.mem_addr), 0);
    chk("rst.pc_enable", 32'(bus.pc_enable), 0);
    chk("rst.pc_load", 32'(bus.pc_load), 0);
    chk("rst.pc_load_value", 32'(bus.pc_load_value), 0);
    chk("rst.instr_out", 32'(bus.instr_out), 0);
    chk("rst.instr_valid", 32'(bus.instr_valid), 0);
    chk("rst.halted", 32'(bus.halted), 0);
    reset = 1;
    @(negedge clk);

    foreach (vecs[v]) begin
      fill_hlt();
      ram[vecs[v].a0] = vecs[v].d0;
      ram[vecs[v].a1] = vecs[v].d1;
      ram[vecs[v].a2] = vecs[v].d2;
      mem_lat = vecs[v].lat;
      void'(model(vecs[v].pc0));
      launch(vecs[v].pc0);
      chk("vec.start_req", 32'(bus.mem_req), 1);
      chk("vec.start_addr", 32'(bus.mem_addr), 32'(vecs[v].pc0));
      run_to_halt(1, 200);
      chk("vec.xfers", xfer_q.size(), vecs[v].xfers);
      chk("vec.last_xfer", 32'(last_xfer), 32'(vecs[v].last));
      chk("vec.pc_end", 32'(pc), 32'(vecs[v].pc_end));
      chk("vec.pc_enables", n_en, vecs[v].en);
      chk("vec.pc_loads", n_ld, vecs[v].ld);
      chk("vec.fetch1", fetch_q.size() > 1 ? 32'(fetch_q[1]) : 'x, 32'(vecs[v].fetch1));
      chk("vec.cycles", cycles, vecs[v].cyc);
      compare("vec");
    end

    fill_hlt();
    ram[0] = 8'h35;
    mem_lat = 1;
    launch(4'h0);
    repeat (3) step(0);
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", 32'(bus.instr_valid), 1);
      chk("bp.instr", 32'(bus.instr_out), 32'h35);
      step(0);
    end
    chk("bp.no_req", n_req, 1);
    step(1);
    chk("bp.xfers", xfer_q.size(), 1);
    chk("bp.req", 32'(bus.mem_req), 1);
    chk("bp.addr", 32'(bus.mem_addr), 1);
    run_to_halt(1, 100);
    chk("bp.stall_stable", n_stall_bad, 0);

    ram[0] = 8'h35;
    mem_lat = 5;
    launch(4'h0);
    step(1);
    step(1);
    reset = 0;
    #1;
    chk("rmo.instr_valid", 32'(bus.instr_valid), 0);
    chk("rmo.instr_out", 32'(bus.instr_out), 0);
    chk("rmo.mem_req", 32'(bus.mem_req), 0);
    chk("rmo.pc_enable", 32'(bus.pc_enable), 0);
    @(negedge clk);
    reset = 1;
    clear_stats();
    repeat (8) step(1);
    chk("rmo.late_rvalid_seen", 32'(saw_rvalid), 1);
    chk("rmo.pc_enables", n_en, 0);
    chk("rmo.reqs", n_req, 0);
    chk("rmo.instr_out", 32'(bus.instr_out), 0);
    chk("rmo.instr_valid", 32'(bus.instr_valid), 0);
    chk("rmo.halted", 32'(bus.halted), 0);

    for (int t = 0; t < 30; t++) begin
      logic [3:0] p0;
      bit ok;
      ok = 0;
      p0 = 4'h0;
      for (int k = 0; k < 200 && !ok; k++) begin
        foreach (ram[i]) ram[i] = 8'($urandom);
        p0 = 4'($urandom);
        ok = model(p0);
      end
      if (!ok) begin
        ram[p0] = 8'hF0;
        void'(model(p0));
      end
      mem_lat = $urandom_range(1, 4);
      launch(p0);
      run_to_halt(2, 3000);
      compare("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
